// File: rtl/debounce_multi_if.sv
// Button-side bundle for debounce_multi: raw inputs in, clean levels and
// event pulses out. The testbench drives through the master modport and
// the debouncer sits on the slave modport.
interface debounce_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] noisy_in;
    logic [N_CH-1:0] level_out;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] long_pulse;
    logic [N_CH-1:0] repeat_pulse;

    modport master (
        output noisy_in,
        input  level_out,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  repeat_pulse
    );

    modport slave (
        input  noisy_in,
        output level_out,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output repeat_pulse
    );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer. Each channel synchronises its raw
// input, filters bounces with a wait window in both directions, and emits
// registered press/release/long-press/auto-repeat pulses. Channels share
// only the clock and reset.
module debounce_multi #(
    parameter int N_CH          = 4,
    parameter int DELAY_MAX     = 100_000,
    parameter int ACTIVE_LOW    = 1,
    parameter int LONG_MAX      = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input logic            clk,
    input logic            rst,
    debounce_multi_if.slave bus
);

    localparam int DW       = $clog2(DELAY_MAX + 1);
    localparam int HOLD_MAX = (LONG_MAX > REPEAT_PERIOD) ? LONG_MAX : REPEAT_PERIOD;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    localparam logic [DW-1:0] DLY_LAST  = DW'(DELAY_MAX - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_MAX - 1);
    // With repeat disabled this value is never compared against.
    localparam logic [HW-1:0] REP_LAST  = (REPEAT_PERIOD > 0) ? HW'(REPEAT_PERIOD - 1) : {HW{1'b0}};
    localparam bit            REPEAT_EN = (REPEAT_PERIOD != 0);
    // Raw level of a released button.
    localparam logic          REL_LVL   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [N_CH-1:0] w_p;
    logic [N_CH-1:0] w_level;
    logic [N_CH-1:0] w_press;
    logic [N_CH-1:0] w_release;
    logic [N_CH-1:0] w_long;
    logic [N_CH-1:0] w_repeat;

    // Two-flop synchroniser on every raw input; resets to the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= {N_CH{REL_LVL}};
            r_sync2 <= {N_CH{REL_LVL}};
        end else begin
            r_sync1 <= bus.noisy_in;
            r_sync2 <= r_sync1;
        end
    end

    // Normalise so that 1 always means "pressed".
    assign w_p = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t        r_state;
        state_t        w_state_nxt;
        logic [DW-1:0] r_cnt;
        logic [DW-1:0] w_cnt_nxt;
        logic [HW-1:0] r_hold;
        logic [HW-1:0] w_hold_nxt;
        logic          r_long_done;
        logic          w_long_done_nxt;
        logic          r_level;
        logic          w_level_nxt;
        logic          r_press;
        logic          w_press_nxt;
        logic          r_release;
        logic          w_release_nxt;
        logic          r_long;
        logic          w_long_nxt;
        logic          r_repeat;
        logic          w_repeat_nxt;

        // Next-state, counter and pulse decode for one channel.
        always_comb begin
            w_state_nxt     = r_state;
            w_cnt_nxt       = r_cnt;
            w_hold_nxt      = r_hold;
            w_long_done_nxt = r_long_done;
            w_level_nxt     = r_level;
            w_press_nxt     = 1'b0;
            w_release_nxt   = 1'b0;
            w_long_nxt      = 1'b0;
            w_repeat_nxt    = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    w_level_nxt = 1'b0;
                    if (w_p[g]) begin
                        w_state_nxt = ST_PRESS_WAIT;
                        w_cnt_nxt   = {DW{1'b0}};
                    end else begin
                        w_cnt_nxt   = {DW{1'b0}};
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_p[g]) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = {DW{1'b0}};
                    end else if (r_cnt == DLY_LAST) begin
                        w_state_nxt     = ST_PRESSED;
                        w_cnt_nxt       = {DW{1'b0}};
                        w_level_nxt     = 1'b1;
                        w_press_nxt     = 1'b1;
                        w_hold_nxt      = {HW{1'b0}};
                        w_long_done_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + DW'(1'b1);
                    end
                end
                ST_PRESSED: begin
                    if (!w_p[g]) begin
                        // Hold timing freezes while the release is qualified.
                        w_state_nxt = ST_RELEASE_WAIT;
                        w_cnt_nxt   = {DW{1'b0}};
                    end else if (!r_long_done && (r_hold == LONG_LAST)) begin
                        w_long_nxt      = 1'b1;
                        w_long_done_nxt = 1'b1;
                        w_hold_nxt      = {HW{1'b0}};
                    end else if (r_long_done && REPEAT_EN && (r_hold == REP_LAST)) begin
                        w_repeat_nxt = 1'b1;
                        w_hold_nxt   = {HW{1'b0}};
                    end else if (r_long_done && !REPEAT_EN) begin
                        w_hold_nxt = r_hold;
                    end else begin
                        w_hold_nxt = r_hold + HW'(1'b1);
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (w_p[g]) begin
                        // Bounce back to pressed: resume the hold timer silently.
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = {DW{1'b0}};
                    end else if (r_cnt == DLY_LAST) begin
                        w_state_nxt     = ST_IDLE;
                        w_cnt_nxt       = {DW{1'b0}};
                        w_level_nxt     = 1'b0;
                        w_release_nxt   = 1'b1;
                        w_hold_nxt      = {HW{1'b0}};
                        w_long_done_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + DW'(1'b1);
                    end
                end
                default: begin
                    w_state_nxt     = ST_IDLE;
                    w_cnt_nxt       = {DW{1'b0}};
                    w_hold_nxt      = {HW{1'b0}};
                    w_long_done_nxt = 1'b0;
                    w_level_nxt     = 1'b0;
                end
            endcase
        end

        // Channel state and registered outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state     <= ST_IDLE;
                r_cnt       <= {DW{1'b0}};
                r_hold      <= {HW{1'b0}};
                r_long_done <= 1'b0;
                r_level     <= 1'b0;
                r_press     <= 1'b0;
                r_release   <= 1'b0;
                r_long      <= 1'b0;
                r_repeat    <= 1'b0;
            end else begin
                r_state     <= w_state_nxt;
                r_cnt       <= w_cnt_nxt;
                r_hold      <= w_hold_nxt;
                r_long_done <= w_long_done_nxt;
                r_level     <= w_level_nxt;
                r_press     <= w_press_nxt;
                r_release   <= w_release_nxt;
                r_long      <= w_long_nxt;
                r_repeat    <= w_repeat_nxt;
            end
        end

        assign w_level[g]   = r_level;
        assign w_press[g]   = r_press;
        assign w_release[g] = r_release;
        assign w_long[g]    = r_long;
        assign w_repeat[g]  = r_repeat;
    end

    assign bus.level_out     = w_level;
    assign bus.press_pulse   = w_press;
    assign bus.release_pulse = w_release;
    assign bus.long_pulse    = w_long;
    assign bus.repeat_pulse  = w_repeat;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: two instances (active-low with repeat, and
// active-high without repeat) checked every cycle against a run-length
// reference model, plus a timing table and directed corner sequences.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] raw [2];

    always #5 clk = ~clk;

    debounce_multi_if #(.N_CH(2)) bus_a ();
    debounce_multi_if #(.N_CH(2)) bus_b ();

    assign bus_a.noisy_in = raw[0];
    assign bus_b.noisy_in = raw[1];

    debounce_multi #(.N_CH(2), .DELAY_MAX(4), .ACTIVE_LOW(1), .LONG_MAX(10), .REPEAT_PERIOD(5))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    debounce_multi #(.N_CH(2), .DELAY_MAX(4), .ACTIVE_LOW(0), .LONG_MAX(10), .REPEAT_PERIOD(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_checks = 0;
    int n_fail   = 0;
    int tick_no  = 0;

    // Reference model parameters per instance.
    int P_D  [2] = '{4, 4};
    bit P_AL [2] = '{1'b1, 1'b0};
    int P_L  [2] = '{10, 10};
    int P_R  [2] = '{5, 0};

    // Reference model: sync delay line, debounced level, length of the current
    // run of disagreeing samples, and number of qualified held cycles.
    bit m_s1 [2][2];
    bit m_s2 [2][2];
    bit m_lvl[2][2];
    int m_run[2][2];
    int m_held[2][2];
    bit m_pr [2][2];
    bit m_rl [2][2];
    bit m_lg [2][2];
    bit m_rp [2][2];

    // Pulses observed from the DUTs since the last clear.
    int acc_press[2][2];
    int acc_rel  [2][2];
    int acc_long [2][2];
    int acc_rep  [2][2];

    typedef struct {
        logic [1:0] in;
        int         n;
        logic [1:0] lvl;
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] lg;
        logic [1:0] rp;
    } vec_t;
    vec_t tbl[12];

    function automatic logic [9:0] dut_out(input int d);
        if (d == 0)
            return {bus_a.level_out, bus_a.press_pulse, bus_a.release_pulse,
                    bus_a.long_pulse, bus_a.repeat_pulse};
        else
            return {bus_b.level_out, bus_b.press_pulse, bus_b.release_pulse,
                    bus_b.long_pulse, bus_b.repeat_pulse};
    endfunction

    function automatic logic [9:0] model_out(input int d);
        return {m_lvl[d][1], m_lvl[d][0], m_pr[d][1], m_pr[d][0], m_rl[d][1], m_rl[d][0],
                m_lg[d][1], m_lg[d][0], m_rp[d][1], m_rp[d][0]};
    endfunction

    task automatic check_vec(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s tick %0d: got lvl/pr/rl/lg/rp=%b required %b", name, tick_no, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s tick %0d: got %0d required %0d", name, tick_no, got, exp);
        end
    endtask

    task automatic clr_acc();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                acc_press[d][c] = 0;
                acc_rel[d][c]   = 0;
                acc_long[d][c]  = 0;
                acc_rep[d][c]   = 0;
            end
    endtask

    task automatic model_edge(input logic r);
        bit p;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                m_pr[d][c] = 1'b0;
                m_rl[d][c] = 1'b0;
                m_lg[d][c] = 1'b0;
                m_rp[d][c] = 1'b0;
                if (r) begin
                    m_s1[d][c]   = P_AL[d];
                    m_s2[d][c]   = P_AL[d];
                    m_lvl[d][c]  = 1'b0;
                    m_run[d][c]  = 0;
                    m_held[d][c] = 0;
                end else begin
                    p = m_s2[d][c] ^ P_AL[d];
                    m_s2[d][c] = m_s1[d][c];
                    m_s1[d][c] = raw[d][c];
                    if (p != m_lvl[d][c]) begin
                        m_run[d][c]++;
                        if (m_run[d][c] == P_D[d] + 1) begin
                            m_lvl[d][c]  = p;
                            m_run[d][c]  = 0;
                            m_held[d][c] = 0;
                            if (p) m_pr[d][c] = 1'b1;
                            else   m_rl[d][c] = 1'b1;
                        end
                    end else begin
                        if (m_lvl[d][c] && m_run[d][c] == 0) begin
                            m_held[d][c]++;
                            if (m_held[d][c] == P_L[d])
                                m_lg[d][c] = 1'b1;
                            else if (P_R[d] != 0 && m_held[d][c] > P_L[d] &&
                                     ((m_held[d][c] - P_L[d]) % P_R[d]) == 0)
                                m_rp[d][c] = 1'b1;
                        end
                        m_run[d][c] = 0;
                    end
                end
            end
    endtask

    task automatic tick();
        logic [9:0] got;
        @(posedge clk);
        model_edge(rst);
        #1;
        tick_no++;
        for (int d = 0; d < 2; d++) begin
            got = dut_out(d);
            check_vec($sformatf("model_dut%0d", d), got, model_out(d));
            for (int c = 0; c < 2; c++) begin
                if (got[6 + c]) acc_press[d][c]++;
                if (got[4 + c]) acc_rel[d][c]++;
                if (got[2 + c]) acc_long[d][c]++;
                if (got[c])     acc_rep[d][c]++;
            end
        end
    endtask

    initial begin
        // Clean-press timeline for instance A, channel 0 (edges counted from the press).
        tbl[0]  = '{2'b10, 6, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{2'b10, 1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
        tbl[2]  = '{2'b10, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[3]  = '{2'b10, 8, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[4]  = '{2'b10, 1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
        tbl[5]  = '{2'b10, 4, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[6]  = '{2'b10, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
        tbl[7]  = '{2'b10, 4, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[8]  = '{2'b10, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
        tbl[9]  = '{2'b11, 6, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[10] = '{2'b11, 1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        tbl[11] = '{2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

        raw[0] = 2'b11;
        raw[1] = 2'b00;
        rst    = 1'b1;
        clr_acc();
        repeat (3) tick();
        check_vec("reset_a", dut_out(0), 10'b0);
        check_vec("reset_b", dut_out(1), 10'b0);
        rst = 1'b0;

        // 1: clean press, long, repeats, release.
        for (int i = 0; i < 12; i++) begin
            raw[0] = tbl[i].in;
            repeat (tbl[i].n) tick();
            check_vec($sformatf("table_%0d", i), dut_out(0),
                      {tbl[i].lvl, tbl[i].pr, tbl[i].rl, tbl[i].lg, tbl[i].rp});
        end

        // 2: short glitch is ignored, a held press qualifies.
        raw[0] = 2'b10;
        repeat (3) tick();
        raw[0] = 2'b11;
        clr_acc();
        repeat (10) tick();
        check_int("glitch_press", acc_press[0][0], 0);
        check_int("glitch_level", int'(bus_a.level_out[0]), 0);
        raw[0] = 2'b10;
        repeat (6) tick();
        check_int("held_not_yet", acc_press[0][0], 0);
        tick();
        check_int("held_press", int'(bus_a.press_pulse[0]), 1);
        raw[0] = 2'b11;
        repeat (8) tick();

        // 3: release bounce gives one release pulse, no re-press.
        raw[0] = 2'b10;
        repeat (9) tick();
        clr_acc();
        raw[0] = 2'b11; repeat (2) tick();
        raw[0] = 2'b10; repeat (2) tick();
        raw[0] = 2'b11;
        repeat (6) tick();
        check_int("bounce_early_rel", acc_rel[0][0], 0);
        check_int("bounce_level_held", int'(bus_a.level_out[0]), 1);
        tick();
        check_int("bounce_rel_edge", int'(bus_a.release_pulse[0]), 1);
        repeat (3) tick();
        check_int("bounce_rel_count", acc_rel[0][0], 1);
        check_int("bounce_no_press", acc_press[0][0], 0);

        // 4: both channels pressed together, channel 1 released early.
        raw[0] = 2'b00;
        repeat (7) tick();
        check_vec("simul_press", dut_out(0), 10'b11_11_00_00_00);
        repeat (3) tick();
        raw[0] = 2'b10;
        repeat (6) tick();
        tick();
        check_vec("simul_rel_long", dut_out(0), 10'b01_00_10_01_00);
        raw[0] = 2'b11;
        repeat (8) tick();

        // 5a: reset during press wait.
        raw[0] = 2'b10;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_vec("rst_wait_zero", dut_out(0), 10'b0);
        clr_acc();
        repeat (6) tick();
        check_int("rst_wait_no_press", acc_press[0][0], 0);
        tick();
        check_int("rst_wait_press", int'(bus_a.press_pulse[0]), 1);
        // 5b: reset while held after the long pulse.
        repeat (12) tick();
        check_int("rst_held_long", acc_long[0][0], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_vec("rst_held_zero", dut_out(0), 10'b0);
        clr_acc();
        repeat (6) tick();
        check_int("rst_held_no_rel", acc_rel[0][0], 0);
        tick();
        check_int("rst_held_press", int'(bus_a.press_pulse[0]), 1);
        raw[0] = 2'b11;
        repeat (8) tick();

        // 6: active-high instance without repeat.
        clr_acc();
        raw[1] = 2'b01;
        repeat (40) tick();
        raw[1] = 2'b00;
        repeat (10) tick();
        check_int("norep_press", acc_press[1][0], 1);
        check_int("norep_long", acc_long[1][0], 1);
        check_int("norep_repeat", acc_rep[1][0], 0);
        check_int("norep_release", acc_rel[1][0], 1);
        check_int("norep_ch1_quiet", acc_press[1][1], 0);

        // Randomised bouncing, alternating fast and slow toggling, rare resets.
        for (int t = 0; t < 3000; t++) begin
            int prob;
            prob = (((t / 500) % 2) == 0) ? 3 : 40;
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < 2; c++)
                    if ($urandom_range(prob - 1, 0) == 0) raw[d][c] = ~raw[d][c];
            rst = ($urandom_range(999, 0) == 0) ? 1'b1 : 1'b0;
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
